// File: rtl/uart_pkg.sv
// Shared UART types and elaboration helpers for the transmit and receive engines.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int unsigned frame_bits(input int unsigned parity, input int unsigned stop_bits);
        return 10 + ((parity != PAR_NONE) ? 1 : 0) + (stop_bits - 1);
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Loadable bit-period down-counter; expire is high for the one cycle the count sits at 0.
module uart_baud_timer #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          expire_q, expire_d;

    // expire is registered alongside the count, so it is asserted exactly while cnt_q == 0
    always_comb begin
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (load) begin
            cnt_d = CW'(DIV - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d    = cnt_q - CW'(1);
            expire_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: turns a txStart/txData handshake into one start/data/parity/stop frame on tx.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       txStart,
    input  logic [7:0] txData,
    output logic       txBusy,
    output logic       txDone,
    output logic       tx
);

    localparam int unsigned DIV     = calc_div(CLK_HZ, BAUD);
    localparam bit          HAS_PAR = (PARITY != PAR_NONE);

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx_engine: CLK_HZ/BAUD must give at least 2 clocks per bit");
    end
    if (PARITY > PAR_EVEN) begin : g_par_chk
        $error("uart_tx_engine: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_stop_chk
        $error("uart_tx_engine: STOP_BITS must be 1 or 2");
    end

    tx_state_t  state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] idx_q, idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic tmr_load;
    logic tmr_en;
    logic tmr_expire;

    assign tmr_en = (state_q != TX_IDLE);

    uart_baud_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .load   (tmr_load),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    // tx_d is the level for the coming bit, so the pin comes straight from a flop
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        par_d      = par_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (txStart) begin
                    shreg_d  = txData;
                    par_d    = (PARITY == PAR_ODD) ? ~^txData : ^txData;
                    tmr_load = 1'b1;
                    state_d  = TX_START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            TX_START: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    idx_d    = 3'd0;
                    state_d  = TX_DATA;
                    tx_d     = shreg_q[0];
                end
            end
            TX_DATA: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    shreg_d  = shreg_q >> 1;
                    idx_d    = idx_q + 3'd1;
                    tx_d     = shreg_q[1];
                    if (idx_q == 3'd7) begin
                        stop_idx_d = 1'b0;
                        if (HAS_PAR) begin
                            state_d = TX_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = TX_STOP;
                            tx_d    = 1'b1;
                        end
                    end
                end
            end
            TX_PARITY: begin
                if (tmr_expire) begin
                    tmr_load   = 1'b1;
                    stop_idx_d = 1'b0;
                    state_d    = TX_STOP;
                    tx_d       = 1'b1;
                end
            end
            TX_STOP: begin
                tx_d = 1'b1;
                if (tmr_expire) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        state_d = TX_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        tmr_load   = 1'b1;
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= TX_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx     = tx_q;
    assign txBusy = busy_q;
    assign txDone = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: three parity/stop configurations against a frame-level model and a UART monitor.
module tb_uart_tx_engine;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DIV    = 10;

    logic       clk;
    logic       rstn;
    logic [2:0] start;
    logic [7:0] data [3];
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] tx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_en = 0;

    // instance 0: 8N1, instance 1: even parity 2 stop, instance 2: odd parity 2 stop
    uart_tx_engine #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rstn(rstn), .txStart(start[0]), .txData(data[0]),
        .txBusy(busy[0]), .txDone(done[0]), .tx(tx[0]));
    uart_tx_engine #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rstn(rstn), .txStart(start[1]), .txData(data[1]),
        .txBusy(busy[1]), .txDone(done[1]), .tx(tx[1]));
    uart_tx_engine #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rstn(rstn), .txStart(start[2]), .txData(data[2]),
        .txBusy(busy[2]), .txDone(done[2]), .tx(tx[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int par_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic int stop_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // Frame model: list of line levels per bit, and cycles elapsed since the accepting edge
    logic m_bits [3][12];
    int   m_fb   [3];
    int   m_off  [3] = '{-1, -1, -1};
    logic m_done [3] = '{1'b0, 1'b0, 1'b0};

    task automatic build_frame(input int i, input logic [7:0] d);
        logic q[$];
        int ones;
        q.push_back(1'b0);
        for (int j = 0; j < 8; j++) q.push_back(d[j]);
        ones = $countones(d);
        if (par_of(i) == 1) q.push_back((ones % 2) == 0);
        if (par_of(i) == 2) q.push_back((ones % 2) == 1);
        for (int s = 0; s < stop_of(i); s++) q.push_back(1'b1);
        m_fb[i] = q.size();
        for (int k = 0; k < q.size(); k++) m_bits[i][k] = q[k];
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            m_done[i] = 1'b0;
            if (!rstn) begin
                m_off[i] = -1;
            end else if (m_off[i] < 0) begin
                if (start[i]) begin
                    build_frame(i, data[i]);
                    m_off[i] = 0;
                end
            end else begin
                m_off[i]++;
                if (m_off[i] == m_fb[i] * DIV) begin
                    m_off[i]  = -1;
                    m_done[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                logic etx;
                etx = (m_off[i] < 0) ? 1'b1 : m_bits[i][m_off[i] / DIV];
                chk($sformatf("model_tx%0d", i), 32'(tx[i]), 32'(etx));
                chk($sformatf("model_busy%0d", i), 32'(busy[i]), 32'(m_off[i] >= 0));
                chk($sformatf("model_done%0d", i), 32'(done[i]), 32'(m_done[i]));
            end
        end
    end

    // Line-level 8N1 monitor on instance 0, sampling mid-bit
    logic [7:0] mon_q[$];
    int         mon_t[$];
    bit         mon_act = 0;
    int         mon_off;
    int         mon_t0;
    logic [7:0] mon_byte;

    always @(negedge clk) begin
        if (!rstn || !cmp_en) begin
            mon_act = 0;
        end else if (!mon_act) begin
            if (tx[0] == 1'b0) begin
                mon_act = 1;
                mon_off = 0;
                mon_t0  = cyc;
            end
        end else begin
            mon_off++;
            if (mon_off >= 15 && mon_off <= 85 && (mon_off % 10) == 5)
                mon_byte[(mon_off - 15) / 10] = tx[0];
            if (mon_off == 95) begin
                chk("mon_stop", 32'(tx[0]), 32'd1);
                mon_q.push_back(mon_byte);
                mon_t.push_back(mon_t0);
                mon_act = 0;
            end
        end
    end

    // Leaves the caller on the negedge just after the accepting edge (frame offset 0)
    task automatic send(input int i, input logic [7:0] b);
        @(negedge clk);
        start[i] = 1'b1;
        data[i]  = b;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_free(input int i);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy[i]) return;
        end
        chk($sformatf("wait_free%0d_timeout", i), 32'd1, 32'd0);
    endtask

    // Checks hand-computed bit levels (bit k = frame bit k), busy length and the done pulse
    task automatic check_frame(input int i, input logic [11:0] exp_bits, input int nb);
        int bc;
        bc = int'(busy[i]);
        for (int c = 1; c <= nb * DIV; c++) begin
            @(negedge clk);
            if ((c % DIV) == 5) chk($sformatf("bit%0d_inst%0d", c / DIV, i), 32'(tx[i]), 32'(exp_bits[c / DIV]));
            if (c < nb * DIV) bc += int'(busy[i]);
        end
        chk($sformatf("busy_len%0d", i), 32'(bc), 32'(nb * DIV));
        chk($sformatf("end_busy%0d", i), 32'(busy[i]), 32'd0);
        chk($sformatf("end_done%0d", i), 32'(done[i]), 32'd1);
        @(negedge clk);
        chk($sformatf("done_width%0d", i), 32'(done[i]), 32'd0);
    endtask

    initial begin
        int dones;
        rstn  = 1'b0;
        start = '0;
        for (int i = 0; i < 3; i++) data[i] = 8'h00;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        @(negedge clk);
        rstn = 1'b1;

        // reset / idle
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            chk("idle_tx", 32'(tx), 32'h7);
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_done", 32'(done), 32'h0);
        end

        // 8N1, 0xA5
        send(0, 8'hA5);
        check_frame(0, 12'b00_1101001010, 10);

        // even parity, 2 stop, 0x07 -> parity 1; odd parity -> 0
        send(1, 8'h07);
        check_frame(1, 12'b1110_0000_1110, 12);
        send(2, 8'h07);
        check_frame(2, 12'b1100_0000_1110, 12);

        // starts during a frame are ignored
        send(0, 8'h3C);
        fork
            check_frame(0, 12'b00_1001111000, 10);
            begin
                repeat (2) @(negedge clk);
                data[0]  = 8'hFF;
                start[0] = 1'b1;
                @(negedge clk);
                start[0] = 1'b0;
                repeat (51) @(negedge clk);
                start[0] = 1'b1;
                @(negedge clk);
                start[0] = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        chk("no_second_frame", 32'(busy[0]), 32'd0);

        // processor loop: next byte on the first txBusy=0 cycle
        mon_q.delete();
        mon_t.delete();
        send(0, 8'h0D);
        wait_free(0);
        start[0] = 1'b1;
        data[0]  = 8'h01;
        @(negedge clk);
        start[0] = 1'b0;
        wait_free(0);
        start[0] = 1'b1;
        data[0]  = 8'h02;
        @(negedge clk);
        start[0] = 1'b0;
        wait_free(0);
        repeat (5) @(negedge clk);
        chk("mon_count", 32'(mon_q.size()), 32'd3);
        if (mon_q.size() == 3) begin
            chk("mon_b0", 32'(mon_q[0]), 32'h0D);
            chk("mon_b1", 32'(mon_q[1]), 32'h01);
            chk("mon_b2", 32'(mon_q[2]), 32'h02);
            chk("mon_gap01", 32'(mon_t[1] - mon_t[0]), 32'd101);
            chk("mon_gap12", 32'(mon_t[2] - mon_t[1]), 32'd101);
        end

        // reset at frame cycle 47 aborts the frame
        send(0, 8'h55);
        repeat (46) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_tx", 32'(tx[0]), 32'd1);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_done", 32'(done[0]), 32'd0);
        repeat (2) @(negedge clk);
        rstn  = 1'b1;
        dones = 0;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            dones += int'(done[0]);
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        send(0, 8'h96);
        check_frame(0, 12'b00_1100101100, 10);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
